// File: rtl/timer_pkg.sv
// Shared watch/timer definitions: field widths, field limits and timer states.
package timer_pkg;

  localparam int MIN_W = 6;
  localparam int SEC_W = 6;
  localparam int CS_W  = 7;

  localparam logic [CS_W-1:0]  CS_MAX  = 7'd99;
  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_STOP    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_if.sv
// Control/preset inputs and display outputs of the countdown timer.
interface countdown_timer_if;
  import timer_pkg::*;

  logic             cs_tick;
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [SEC_W-1:0] load_sec;
  logic [CS_W-1:0]  load_cs;
  logic             start_stop;
  logic             clear;
  logic [MIN_W-1:0] minutes;
  logic [SEC_W-1:0] seconds;
  logic [CS_W-1:0]  m_seconds;
  logic             running;
  logic             expired;
  logic             alarm;

  modport master (
    output cs_tick, load, load_min, load_sec, load_cs, start_stop, clear,
    input  minutes, seconds, m_seconds, running, expired, alarm
  );

  modport slave (
    input  cs_tick, load, load_min, load_sec, load_cs, start_stop, clear,
    output minutes, seconds, m_seconds, running, expired, alarm
  );
endinterface

// File: rtl/mmss_decrement.sv
// Combinational mm:ss:cc borrow-chain decrement with zero-result flag.
module mmss_decrement
  import timer_pkg::*;
(
  input  logic [MIN_W-1:0] min_i,
  input  logic [SEC_W-1:0] sec_i,
  input  logic [CS_W-1:0]  cs_i,
  output logic [MIN_W-1:0] min_o,
  output logic [SEC_W-1:0] sec_o,
  output logic [CS_W-1:0]  cs_o,
  output logic             is_zero_next_o
);

  // Borrow centiseconds -> seconds -> minutes; 00:00:00 holds rather than wraps.
  always_comb begin
    min_o = min_i;
    sec_o = sec_i;
    cs_o  = cs_i;
    if (cs_i != '0) begin
      cs_o = cs_i - 7'd1;
    end else if (sec_i != '0) begin
      cs_o  = CS_MAX;
      sec_o = sec_i - 6'd1;
    end else if (min_i != '0) begin
      cs_o  = CS_MAX;
      sec_o = SEC_MAX;
      min_o = min_i - 6'd1;
    end
  end

  assign is_zero_next_o = (min_o == '0) && (sec_o == '0) && (cs_o == '0);

endmodule

// File: rtl/countdown_timer.sv
// Min:sec:centisecond countdown timer with preset load, run/pause and alarm.
module countdown_timer
  import timer_pkg::*;
(
  input  logic             m_clk,
  input  logic             rst_n,
  countdown_timer_if.slave bus
);

  state_e           state_q;
  logic [MIN_W-1:0] min_q, min_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [CS_W-1:0]  cs_q, cs_d;
  logic             running_q, expired_q, alarm_q;
  logic             zero_d;
  logic             count_nz;

  mmss_decrement u_dec (
    .min_i          (min_q),
    .sec_i          (sec_q),
    .cs_i           (cs_q),
    .min_o          (min_d),
    .sec_o          (sec_d),
    .cs_o           (cs_d),
    .is_zero_next_o (zero_d)
  );

  assign count_nz = (min_q != '0) || (sec_q != '0) || (cs_q != '0);

  // Controls resolved in priority order clear > load > start_stop > cs_tick;
  // a start_stop always swallows a coincident tick.
  always_ff @(posedge m_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STOP;
      min_q     <= '0;
      sec_q     <= '0;
      cs_q      <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      expired_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= ST_STOP;
        min_q     <= '0;
        sec_q     <= '0;
        cs_q      <= '0;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
      end else if (bus.load && state_q != ST_RUN) begin
        state_q   <= ST_STOP;
        min_q     <= (bus.load_min > MIN_MAX) ? MIN_MAX : bus.load_min;
        sec_q     <= (bus.load_sec > SEC_MAX) ? SEC_MAX : bus.load_sec;
        cs_q      <= (bus.load_cs  > CS_MAX)  ? CS_MAX  : bus.load_cs;
        running_q <= 1'b0;
        alarm_q   <= 1'b0;
      end else if (bus.start_stop) begin
        if (state_q == ST_STOP && count_nz) begin
          state_q   <= ST_RUN;
          running_q <= 1'b1;
        end else if (state_q == ST_RUN) begin
          state_q   <= ST_STOP;
          running_q <= 1'b0;
        end
      end else if (bus.cs_tick && state_q == ST_RUN) begin
        min_q <= min_d;
        sec_q <= sec_d;
        cs_q  <= cs_d;
        if (zero_d) begin
          state_q   <= ST_EXPIRED;
          running_q <= 1'b0;
          expired_q <= 1'b1;
          alarm_q   <= 1'b1;
        end
      end
    end
  end

  assign bus.minutes   = min_q;
  assign bus.seconds   = sec_q;
  assign bus.m_seconds = cs_q;
  assign bus.running   = running_q;
  assign bus.expired   = expired_q;
  assign bus.alarm     = alarm_q;

endmodule
